// File: rtl/pixel_class_pkg.sv
// Shared definitions for the pixel classifier: config field encodings,
// default colour-box bounds and cfg_addr decode helpers.
package pixel_class_pkg;

    localparam int FLD_W = 3;
    localparam int N_CH  = 3;

    typedef enum logic [FLD_W-1:0] {
        FLD_RMIN = 3'd0,
        FLD_RMAX = 3'd1,
        FLD_GMIN = 3'd2,
        FLD_GMAX = 3'd3,
        FLD_BMIN = 3'd4,
        FLD_BMAX = 3'd5,
        FLD_EN   = 3'd6,
        FLD_RSVD = 3'd7
    } cfg_field_e;

    // Reset bound of a colour box: min is 0, max is all-ones, so an enabled
    // but otherwise untouched box matches every pixel.
    function automatic int unsigned dflt_bound(int unsigned ch_w, bit is_max);
        return is_max ? ((32'd1 << ch_w) - 32'd1) : 32'd0;
    endfunction

    function automatic int unsigned cfg_cls(int unsigned addr);
        return addr >> FLD_W;
    endfunction

    function automatic cfg_field_e cfg_fld(int unsigned addr);
        return cfg_field_e'(addr[FLD_W-1:0]);
    endfunction

endpackage

// File: rtl/pixel_class_box.sv
// One programmable colour box: inclusive unsigned range test on R, G and B,
// qualified by the box enable.
module pixel_class_box
    import pixel_class_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic [N_CH*CH_W-1:0] pixel_i,
    input  logic [N_CH*CH_W-1:0] lo_i,
    input  logic [N_CH*CH_W-1:0] hi_i,
    input  logic                 en_i,
    output logic                 match_o
);

    logic [N_CH-1:0] in_rng;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign in_rng[gi] = (pixel_i[gi*CH_W +: CH_W] >= lo_i[gi*CH_W +: CH_W]) &&
                            (pixel_i[gi*CH_W +: CH_W] <= hi_i[gi*CH_W +: CH_W]);
    end

    // min > max leaves the range empty, so such a box can never match.
    assign match_o = en_i && (&in_rng);

endmodule

// File: rtl/pixel_class_stream.sv
// Streaming RGB classifier: N_CLASS colour boxes, two-stage valid/ready pipe,
// per-frame hit counters with an end-of-frame snapshot for the host.
module pixel_class_stream
    import pixel_class_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int N_CLASS = 7,
    parameter int CLS_W   = $clog2(N_CLASS + 1),
    parameter int CNT_W   = 20
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [CLS_W+2:0]     cfg_addr_i,
    input  logic [CH_W-1:0]      cfg_wdata_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [3*CH_W-1:0]    s_pixel_i,
    input  logic                 s_sop_i,
    input  logic                 s_eop_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [CLS_W-1:0]     m_class_o,
    output logic                 m_sop_o,
    output logic                 m_eop_o,
    output logic                 stat_valid_o,
    input  logic [CLS_W-1:0]     stat_sel_i,
    output logic [CNT_W-1:0]     stat_count_o
);

    localparam logic [CH_W-1:0] MIN_RST = CH_W'(dflt_bound(CH_W, 1'b0));
    localparam logic [CH_W-1:0] MAX_RST = CH_W'(dflt_bound(CH_W, 1'b1));

    logic                adv;
    logic                out_hs;
    int unsigned         wr_cls;
    cfg_field_e          wr_fld;
    logic [N_CLASS:1]    match_vec;

    logic                s1_valid_q, s1_sop_q, s1_eop_q;
    logic [N_CLASS:1]    s1_match_q;
    logic [CLS_W-1:0]    cls_d;
    logic                m_valid_q, m_sop_q, m_eop_q, stat_valid_q;
    logic [CLS_W-1:0]    m_class_q;
    logic [CNT_W-1:0]    snap_all [N_CLASS+1];

    assign adv       = !m_valid_q || m_ready_i;
    assign out_hs    = m_valid_q && m_ready_i;
    assign s_ready_o = adv;
    assign wr_cls    = cfg_cls(32'(cfg_addr_i));
    assign wr_fld    = cfg_fld(32'(cfg_addr_i));

    for (genvar gi = 1; gi <= N_CLASS; gi++) begin : g_cls
        logic [CH_W-1:0] lo_q [N_CH];
        logic [CH_W-1:0] hi_q [N_CH];
        logic            en_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int c = 0; c < N_CH; c++) begin
                    lo_q[c] <= MIN_RST;
                    hi_q[c] <= MAX_RST;
                end
                en_q <= 1'b0;
            end else if (cfg_we_i && wr_cls == gi) begin
                case (wr_fld)
                    FLD_RMIN: lo_q[0] <= cfg_wdata_i;
                    FLD_RMAX: hi_q[0] <= cfg_wdata_i;
                    FLD_GMIN: lo_q[1] <= cfg_wdata_i;
                    FLD_GMAX: hi_q[1] <= cfg_wdata_i;
                    FLD_BMIN: lo_q[2] <= cfg_wdata_i;
                    FLD_BMAX: hi_q[2] <= cfg_wdata_i;
                    FLD_EN:   en_q    <= cfg_wdata_i[0];
                    default:  ;
                endcase
            end
        end

        // Index 0 is red, which sits in the top bits of the pixel word.
        pixel_class_box #(.CH_W(CH_W)) u_box (
            .pixel_i (s_pixel_i),
            .lo_i    ({lo_q[0], lo_q[1], lo_q[2]}),
            .hi_i    ({hi_q[0], hi_q[1], hi_q[2]}),
            .en_i    (en_q),
            .match_o (match_vec[gi])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_match_q <= '0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            m_valid_q  <= 1'b0;
            m_class_q  <= '0;
            m_sop_q    <= 1'b0;
            m_eop_q    <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= s_valid_i;
            s1_match_q <= match_vec;
            s1_sop_q   <= s_valid_i && s_sop_i;
            s1_eop_q   <= s_valid_i && s_eop_i;
            m_valid_q  <= s1_valid_q;
            m_class_q  <= cls_d;
            m_sop_q    <= s1_sop_q;
            m_eop_q    <= s1_eop_q;
        end
    end

    // Scan downwards so the lowest matching class is the last one written.
    always_comb begin
        cls_d = '0;
        for (int k = N_CLASS; k >= 1; k--) begin
            if (s1_match_q[k]) cls_d = CLS_W'(k);
        end
    end

    for (genvar gi = 0; gi <= N_CLASS; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d, snap_q;
        logic             hit;

        assign hit = (m_class_q == CLS_W'(gi));

        always_comb begin
            cnt_d = cnt_q;
            if (m_sop_q)
                cnt_d = hit ? CNT_W'(1) : '0;
            else if (hit && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q  <= '0;
                snap_q <= '0;
            end else if (out_hs) begin
                cnt_q <= cnt_d;
                if (m_eop_q) snap_q <= cnt_d;
            end
        end

        assign snap_all[gi] = snap_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) stat_valid_q <= 1'b0;
        else         stat_valid_q <= out_hs && m_eop_q;
    end

    always_comb begin
        stat_count_o = '0;
        if (32'(stat_sel_i) <= N_CLASS) stat_count_o = snap_all[stat_sel_i];
    end

    assign m_valid_o    = m_valid_q;
    assign m_class_o    = m_class_q;
    assign m_sop_o      = m_sop_q;
    assign m_eop_o      = m_eop_q;
    assign stat_valid_o = stat_valid_q;

endmodule

// File: tb/tb_pixel_class_stream.sv
// Directed bench for pixel_class_stream; a second instance with 4-bit
// counters shares the stimulus and is used for the saturation case.
module tb_pixel_class_stream;

    localparam int CH_W = 8, N_CLASS = 7, CLS_W = 3, CNT_W = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_ni = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CLS_W+2:0]  cfg_addr = '0;
    logic [CH_W-1:0]   cfg_wdata = '0;
    logic              s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
    logic [3*CH_W-1:0] s_pixel = '0;
    logic              m_ready = 1'b1;
    logic [CLS_W-1:0]  stat_sel = '0;
    logic              s_ready, m_valid, m_sop, m_eop, stat_valid;
    logic [CLS_W-1:0]  m_class;
    logic [CNT_W-1:0]  stat_count;
    logic              s_ready_sat, m_valid_sat, m_sop_sat, m_eop_sat, stat_valid_sat;
    logic [CLS_W-1:0]  m_class_sat;
    logic [3:0]        stat_count_sat;

    pixel_class_stream #(.CH_W(CH_W), .N_CLASS(N_CLASS), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .s_pixel_i(s_pixel), .s_sop_i(s_sop), .s_eop_i(s_eop),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_class_o(m_class),
        .m_sop_o(m_sop), .m_eop_o(m_eop), .stat_valid_o(stat_valid),
        .stat_sel_i(stat_sel), .stat_count_o(stat_count)
    );

    pixel_class_stream #(.CH_W(CH_W), .N_CLASS(N_CLASS), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_ni), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_wdata_i(cfg_wdata), .s_valid_i(s_valid), .s_ready_o(s_ready_sat),
        .s_pixel_i(s_pixel), .s_sop_i(s_sop), .s_eop_i(s_eop),
        .m_valid_o(m_valid_sat), .m_ready_i(m_ready), .m_class_o(m_class_sat),
        .m_sop_o(m_sop_sat), .m_eop_o(m_eop_sat), .stat_valid_o(stat_valid_sat),
        .stat_sel_i(stat_sel), .stat_count_o(stat_count_sat)
    );

    int total = 0, bad = 0, n_out = 0;
    logic [4:0] exp_q [$];
    int mn [1:N_CLASS][3];
    int mx [1:N_CLASS][3];
    int en [1:N_CLASS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic reset_model();
        for (int k = 1; k <= N_CLASS; k++) begin
            for (int c = 0; c < 3; c++) begin
                mn[k][c] = 0;
                mx[k][c] = 255;
            end
            en[k] = 0;
        end
    endtask

    task automatic model_write(input int cls, input int fld, input logic [7:0] data);
        if (fld < 6) begin
            if (fld % 2 == 0) mn[cls][fld/2] = int'(data);
            else              mx[cls][fld/2] = int'(data);
        end else if (fld == 6) begin
            en[cls] = int'(data[0]);
        end
    endtask

    function automatic logic [2:0] classify(input logic [23:0] p);
        int ch [3];
        logic [2:0] r;
        ch[0] = int'(p[23:16]);
        ch[1] = int'(p[15:8]);
        ch[2] = int'(p[7:0]);
        r = 3'd0;
        for (int k = N_CLASS; k >= 1; k--) begin
            if (en[k] != 0 && ch[0] >= mn[k][0] && ch[0] <= mx[k][0] &&
                ch[1] >= mn[k][1] && ch[1] <= mx[k][1] &&
                ch[2] >= mn[k][2] && ch[2] <= mx[k][2])
                r = 3'(k);
        end
        return r;
    endfunction

    // All driving tasks start and end 1 ns after a rising edge.
    task automatic cfg_write(input int cls, input int fld, input logic [7:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = {3'(cls), 3'(fld)};
        cfg_wdata = data;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        model_write(cls, fld, data);
    endtask

    // exp_cls < 0 asks the model; otherwise it is a hand-computed class.
    task automatic send_pixel(input logic [23:0] pix, input bit sop, input bit eop, input int exp_cls);
        bit ok;
        logic [2:0] ec;
        ok = 1'b0;
        s_valid = 1'b1;
        s_pixel = pix;
        s_sop   = sop;
        s_eop   = eop;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ec = (exp_cls < 0) ? classify(pix) : 3'(exp_cls);
                exp_q.push_back({ec, sop, eop});
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_stat();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (stat_valid) pulses++;
        end
        @(posedge clk); #1;
        check("stat_pulse", 32'(pulses), 32'd1);
    endtask

    task automatic rd_stat(input string tag, input int sel, input int exp);
        stat_sel = 3'(sel);
        #1;
        check(tag, 32'(stat_count), 32'(exp));
    endtask

    task automatic rd_stat_sat(input string tag, input int sel, input int exp);
        stat_sel = 3'(sel);
        #1;
        check(tag, 32'(stat_count_sat), 32'(exp));
    endtask

    // Output monitor: every handshake pops the model queue; a stalled output
    // must keep presenting the oldest outstanding pixel.
    always @(negedge clk) begin
        if (rst_ni && m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else if (m_ready) begin
                check("out", 32'({m_class, m_sop, m_eop}), 32'(exp_q.pop_front()));
                n_out++;
            end else begin
                check("hold", 32'({m_class, m_sop, m_eop}), 32'(exp_q[0]));
            end
        end
    end

    logic [23:0] tbl [4] = '{24'hE01010, 24'h10E010, 24'hC83C3C, 24'h123456};

    initial begin
        int n0;
        logic [23:0] pix;
        reset_model();

        #12;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_class", 32'(m_class), 32'd0);
        check("rst_stat_valid", 32'(stat_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        stat_sel = 3'd1; #1;
        check("rst_stat_count", 32'(stat_count), 32'd0);
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Default config: everything classifies as 0; two-edge latency.
        send_pixel(24'h123456, 1'b0, 1'b0, 0);
        check("lat_e0", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_e1", 32'(m_valid), 32'd1);
        for (int i = 0; i < 3; i++) send_pixel(24'h123456, 1'b0, 1'b0, 0);
        drain();

        // Priority and no-match.
        cfg_write(1, 0, 8'd200); cfg_write(1, 1, 8'd255);
        cfg_write(1, 2, 8'd0);   cfg_write(1, 3, 8'd60);
        cfg_write(1, 4, 8'd0);   cfg_write(1, 5, 8'd60);
        cfg_write(1, 6, 8'd1);   cfg_write(2, 6, 8'd1);
        send_pixel(24'hE01010, 1'b0, 1'b0, 1);
        send_pixel(24'h10E010, 1'b0, 1'b0, 2);
        cfg_write(2, 6, 8'd0);
        send_pixel(24'h10E010, 1'b0, 1'b0, 0);
        send_pixel(24'hC83C3C, 1'b0, 1'b0, 1);
        send_pixel(24'hC73C3C, 1'b0, 1'b0, 0);
        send_pixel(24'hC83D3C, 1'b0, 1'b0, 0);
        cfg_write(3, 0, 8'd100); cfg_write(3, 1, 8'd50); cfg_write(3, 6, 8'd1);
        send_pixel(24'h4B0000, 1'b0, 1'b0, 0);
        drain();

        // Backpressure with 20 random pixels against the model.
        cfg_write(2, 6, 8'd1);
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    pix = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 3)] : 24'($urandom);
                    send_pixel(pix, i == 0, i == 19, -1);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #2 m_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("bp_s_ready", 32'(s_ready), 32'd0);
                repeat (2) @(posedge clk);
                #2 m_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 32'(n_out - n0), 32'd20);

        // Frame of 6 class-1 and 4 class-0 pixels.
        cfg_write(2, 6, 8'd0);
        for (int i = 0; i < 10; i++)
            send_pixel(i < 6 ? 24'hE01010 : 24'h10E010, i == 0, i == 9, i < 6 ? 1 : 0);
        wait_stat();
        rd_stat("frm_sel0", 0, 4);
        rd_stat("frm_sel1", 1, 6);
        rd_stat("frm_sel2", 2, 0);

        // Single-pixel frame; its sop clears the previous frame's counts.
        cfg_write(2, 6, 8'd1);
        send_pixel(24'h10E010, 1'b1, 1'b1, 2);
        wait_stat();
        rd_stat("one_sel0", 0, 0);
        rd_stat("one_sel1", 1, 0);
        rd_stat("one_sel2", 2, 1);

        // 20-pixel frame: 4-bit counters saturate at 15.
        for (int i = 0; i < 20; i++) send_pixel(24'hE01010, i == 0, i == 19, 1);
        wait_stat();
        rd_stat_sat("sat_sel1", 1, 15);
        rd_stat("wide_sel1", 1, 20);

        // Config write on the accept edge of pixel N.
        cfg_we    = 1'b1;
        cfg_addr  = {3'd1, 3'd6};
        cfg_wdata = 8'd0;
        send_pixel(24'hE01010, 1'b0, 1'b0, 1);
        cfg_we = 1'b0;
        model_write(1, 6, 8'd0);
        send_pixel(24'hE01010, 1'b0, 1'b0, 2);
        drain();

        // Mid-frame asynchronous reset with the pipe full and stalled.
        m_ready = 1'b0;
        send_pixel(24'hE01010, 1'b1, 1'b0, 2);
        send_pixel(24'hE01010, 1'b0, 1'b0, 2);
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        exp_q.delete();
        reset_model();
        m_ready = 1'b1;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        rd_stat("rst_snap", 1, 0);
        send_pixel(24'hE01010, 1'b1, 1'b1, 0);
        send_pixel(24'h10E010, 1'b0, 1'b0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
